// File: rtl/alg_unit_sequencer_pkg.sv
// rtl/alg_unit_sequencer_pkg.sv - op_x encodings, sequencer state type and shared constants
package alg_unit_sequencer_pkg;

    // op_x_bits encodings of the multiply/divide group
    localparam logic [2:0] op_mul    = 3'b001;
    localparam logic [2:0] op_div    = 3'b010;
    localparam logic [2:0] op_hi_mul = 3'b011;
    localparam logic [2:0] op_rem    = 3'b100;

    // Quotient reported when the divisor is zero
    localparam logic [15:0] ALG_DIV0_QUOT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        FIX,
        DONE
    } alg_state_t;

    // Only op_mul and op_div start the unit; op_hi_mul/op_rem just read result_hi
    function automatic logic is_alg_op(input logic [2:0] op_x);
        return (op_x == op_mul) || (op_x == op_div);
    endfunction

endpackage

// File: rtl/alg_unit_sequencer_if.sv
// rtl/alg_unit_sequencer_if.sv - EXE-stage handshake between pipeline and multiply/divide unit
interface alg_unit_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       op_x_bits;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;

    // Pipeline side: issues the operation and watches stall/results
    modport master (
        output start, op_x_bits, opA, opB,
        input  stall, busy, done, result_lo, result_hi, div_by_zero
    );

    // Unit side
    modport slave (
        input  start, op_x_bits, opA, opB,
        output stall, busy, done, result_lo, result_hi, div_by_zero
    );
endinterface

// File: rtl/alg_sign_fix.sv
// rtl/alg_sign_fix.sv - combinational conditional two's-complement negate (magnitude / sign restore)
module alg_sign_fix #(
    parameter int N = 16
) (
    input  logic [N-1:0] value,
    input  logic         negate,
    output logic [N-1:0] result
);

    // Negating a negative operand yields its magnitude; 16'h8000 maps to itself
    always_comb begin
        result = negate ? (~value + N'(1)) : value;
    end

endmodule

// File: rtl/alg_unit_sequencer.sv
// rtl/alg_unit_sequencer.sv - iterative signed multiply/divide sequencer (optional ALG_EARLY_TERM_EN)
module alg_unit_sequencer
    import alg_unit_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    alg_unit_sequencer_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    alg_state_t         state;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic [2*WIDTH-1:0] acc;        // {product hi, multiplier/product lo} or {remainder, quotient}
    logic [WIDTH-1:0]   dvsr;       // multiplicand magnitude (mul) or divisor magnitude (div)
    logic [CW-1:0]      cnt;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   res_lo_q;
    logic [WIDTH-1:0]   res_hi_q;

    logic               accept;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_trial;
    logic [WIDTH-1:0]   rem_diff;

    // A new operation is taken only from IDLE/DONE; reset masks it so stall stays low
    assign accept = reset_n && bus.start && is_alg_op(bus.op_x_bits)
                    && ((state == IDLE) || (state == DONE));

    // The issuing instruction must freeze in its own cycle, hence the combinational accept term
    assign bus.stall       = accept | busy_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result_lo   = res_lo_q;
    assign bus.result_hi   = res_hi_q;
    assign bus.div_by_zero = dbz_q;

    alg_sign_fix #(.N(WIDTH)) u_mag_a (
        .value  (bus.opA),
        .negate (bus.opA[WIDTH-1]),
        .result (abs_a)
    );

    alg_sign_fix #(.N(WIDTH)) u_mag_b (
        .value  (bus.opB),
        .negate (bus.opB[WIDTH-1]),
        .result (abs_b)
    );

    alg_sign_fix #(.N(2*WIDTH)) u_fix_prod (
        .value  (acc),
        .negate (sign_a ^ sign_b),
        .result (prod_fixed)
    );

    alg_sign_fix #(.N(WIDTH)) u_fix_quot (
        .value  (acc[WIDTH-1:0]),
        .negate (sign_a ^ sign_b),
        .result (quot_fixed)
    );

    // Remainder follows the dividend's sign
    alg_sign_fix #(.N(WIDTH)) u_fix_rem (
        .value  (acc[2*WIDTH-1:WIDTH]),
        .negate (sign_a),
        .result (rem_fixed)
    );

    // One shift-add (mul) or restoring shift-subtract (div) step on the working register
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, dvsr};
        rem_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff  = rem_trial[WIDTH-1:0] - dvsr;
        if (is_div) begin
            if (rem_trial >= {1'b0, dvsr}) begin
                acc_next = {rem_diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

`ifdef ALG_EARLY_TERM_EN
    logic [WIDTH-1:0]   live_mask;
    logic [CW:0]        left_cnt;
    logic               early_exit;
    logic [2*WIDTH-1:0] acc_skip;

    // After cnt steps the unconsumed multiplier bits sit in acc[WIDTH-1-cnt:0]; if they are
    // all zero the remaining steps are pure shifts and can be collapsed into one
    always_comb begin
        live_mask  = {WIDTH{1'b1}} >> cnt;
        left_cnt   = (CW+1)'(WIDTH) - {1'b0, cnt};
        early_exit = !is_div && ((acc[WIDTH-1:0] & live_mask) == '0);
        acc_skip   = acc >> left_cnt;
    end
`endif

    // Sequencer FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            acc      <= '0;
            dvsr     <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state  <= LOAD;
                        busy_q <= 1'b1;
                        is_div <= (bus.op_x_bits == op_div);
                        dbz_q  <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                LOAD: begin
                    sign_a <= bus.opA[WIDTH-1];
                    sign_b <= bus.opB[WIDTH-1];
                    cnt    <= '0;
                    if (is_div) begin
                        acc  <= {{WIDTH{1'b0}}, abs_a};
                        dvsr <= abs_b;
                        if (bus.opB == '0) begin
                            res_lo_q <= WIDTH'(ALG_DIV0_QUOT);
                            res_hi_q <= bus.opA;
                            dbz_q    <= 1'b1;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= ITER;
                        end
                    end else begin
                        acc   <= {{WIDTH{1'b0}}, abs_b};
                        dvsr  <= abs_a;
                        state <= ITER;
                    end
                end
                ITER: begin
`ifdef ALG_EARLY_TERM_EN
                    if (early_exit) begin
                        acc   <= acc_skip;
                        state <= FIX;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST_CNT) begin
                            state <= FIX;
                        end
                    end
`else
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_CNT) begin
                        state <= FIX;
                    end
`endif
                end
                FIX: begin
                    if (is_div) begin
                        res_lo_q <= quot_fixed;
                        res_hi_q <= rem_fixed;
                    end else begin
                        res_lo_q <= prod_fixed[WIDTH-1:0];
                        res_hi_q <= prod_fixed[2*WIDTH-1:WIDTH];
                    end
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
